// File: rtl/ldpc_wb_initiator.sv
// ldpc_wb_initiator
// Wishbone classic-cycle initiator for the LDPC CSR window. Commands are
// queued in a small FIFO and executed one single-beat bus cycle at a time.
// Each command produces exactly one response, in command order.
//
// Optional feature macro: LDPC_WBM_TIMEOUT_EN
//   defined   -> an 8-bit watchdog aborts a REQ phase after TIMEOUT cycles
//   undefined -> no watchdog; REQ waits for ack/err indefinitely
//
// Ports
//   wb_clk_i, wb_rst_i       clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (cmd_ready = FIFO not full)
//   cmd_we/adr/dat/sel       command fields (adr is a 13-bit CSR byte offset)
//   rsp_valid/rsp_ready      response handshake
//   rsp_dat/err/we           read data (0 on write/error), error flag, echo of we
//   wbm_*                    Wishbone initiator bus
//   busy                     FSM not idle or FIFO not empty
module ldpc_wb_initiator #(
  parameter logic [31:0] ADDR_BASE  = 32'h3001_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          TIMEOUT    = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [12:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        rsp_we,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic [31:0] wbm_dat_i,
  output logic        busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = 1 + 13 + 32 + 4;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RSP
  } state_t;

  // ---------------------------------------------------------------------
  // Command FIFO: entry = {we, adr[12:0], dat[31:0], sel[3:0]}
  // ---------------------------------------------------------------------
  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          push, pop;
  logic [EW-1:0] head;

  state_t state_reg, state_next;

  assign cmd_ready = (count_reg != DEPTH_C);
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state_reg == ST_IDLE) && (count_reg != '0);
  assign head      = fifo_mem[rd_ptr_reg];

  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {cmd_we, cmd_adr, cmd_dat, cmd_sel};
    end
  end

  // Pointer arithmetic wraps naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Bus / response registers
  // ---------------------------------------------------------------------
  logic        cyc_reg, cyc_next;
  logic        we_reg, we_next;
  logic [3:0]  sel_reg, sel_next;
  logic [31:0] adr_reg, adr_next;
  logic [31:0] dat_o_reg, dat_o_next;
  logic        rsp_valid_reg, rsp_valid_next;
  logic [31:0] rsp_dat_reg, rsp_dat_next;
  logic        rsp_err_reg, rsp_err_next;
  logic        rsp_we_reg, rsp_we_next;
  logic        abort;

`ifdef LDPC_WBM_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] to_cnt_reg, to_cnt_next;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) to_cnt_reg <= '0;
    else          to_cnt_reg <= to_cnt_next;
  end

  // Fires in the last allowed REQ cycle; ack/err are checked first below.
  assign abort = (state_reg == ST_REQ) && (to_cnt_reg == TO_LAST);
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
  assign abort = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg     <= ST_IDLE;
      cyc_reg       <= 1'b0;
      we_reg        <= 1'b0;
      sel_reg       <= '0;
      adr_reg       <= '0;
      dat_o_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_dat_reg   <= '0;
      rsp_err_reg   <= 1'b0;
      rsp_we_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cyc_reg       <= cyc_next;
      we_reg        <= we_next;
      sel_reg       <= sel_next;
      adr_reg       <= adr_next;
      dat_o_reg     <= dat_o_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_dat_reg   <= rsp_dat_next;
      rsp_err_reg   <= rsp_err_next;
      rsp_we_reg    <= rsp_we_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cyc_next       = cyc_reg;
    we_next        = we_reg;
    sel_next       = sel_reg;
    adr_next       = adr_reg;
    dat_o_next     = dat_o_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_dat_next   = rsp_dat_reg;
    rsp_err_next   = rsp_err_reg;
    rsp_we_next    = rsp_we_reg;
`ifdef LDPC_WBM_TIMEOUT_EN
    to_cnt_next    = to_cnt_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (count_reg != '0) begin
          cyc_next   = 1'b1;
          we_next    = head[49];
          adr_next   = {ADDR_BASE[31:13], head[48:36]};
          dat_o_next = head[35:4];
          sel_next   = head[3:0];
          state_next = ST_REQ;
`ifdef LDPC_WBM_TIMEOUT_EN
          to_cnt_next = '0;
`endif
        end
      end

      ST_REQ: begin
        if (wbm_ack_i || wbm_err_i || abort) begin
          // Ack has priority over err, and both over the watchdog.
          rsp_valid_next = 1'b1;
          rsp_we_next    = we_reg;
          rsp_err_next   = ~wbm_ack_i;
          rsp_dat_next   = (wbm_ack_i && !we_reg) ? wbm_dat_i : 32'h0;
          // Bus outputs return to zero together with cyc.
          cyc_next       = 1'b0;
          we_next        = 1'b0;
          sel_next       = '0;
          adr_next       = '0;
          dat_o_next     = '0;
          state_next     = ST_RSP;
        end else begin
`ifdef LDPC_WBM_TIMEOUT_EN
          to_cnt_next = to_cnt_reg + 8'd1;
`endif
        end
      end

      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          rsp_dat_next   = '0;
          rsp_err_next   = 1'b0;
          rsp_we_next    = 1'b0;
          state_next     = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign wbm_cyc_o = cyc_reg;
  assign wbm_stb_o = cyc_reg;
  assign wbm_we_o  = we_reg;
  assign wbm_sel_o = sel_reg;
  assign wbm_adr_o = adr_reg;
  assign wbm_dat_o = dat_o_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_dat   = rsp_dat_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_we    = rsp_we_reg;
  assign busy      = (state_reg != ST_IDLE) || (count_reg != '0);

endmodule

// File: tb/tb_ldpc_wb_initiator.sv
// Testbench for ldpc_wb_initiator: bus-side responder model plus scoreboards
// of expected bus cycles and expected responses, filled when commands are
// pushed and drained as the DUT produces bus cycles and responses.
module tb_ldpc_wb_initiator;

  localparam logic [31:0] BASE    = 32'h3001_0000;
  localparam int          TO      = 16;
  localparam logic [12:0] ERR_ADR = 13'h1EE;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [12:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_we;
  logic [31:0] rsp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic        wbm_ack_i = 1'b0, wbm_err_i = 1'b0;
  logic [31:0] wbm_dat_i = 32'h0;
  logic        busy;

  always #5 clk = ~clk;

  ldpc_wb_initiator #(.ADDR_BASE(BASE), .FIFO_DEPTH(4), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_err(rsp_err), .rsp_we(rsp_we),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_dat_i(wbm_dat_i),
    .busy(busy)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } bus_t;

  typedef struct {
    logic [31:0] dat;
    logic        err;
    logic        we;
  } rsp_t;

  bus_t bus_q[$];
  rsp_t rsp_q[$];
  int   rise_q[$];

  int passed = 0;
  int total  = 0;
  int cyc_n  = 0;

  // Responder configuration: ack_after = k acks in the k-th REQ cycle,
  // 0 = never respond. Offset ERR_ADR answers with err instead of ack.
  int          ack_after = 1;
  bit          ovr_en = 1'b0;
  logic [31:0] ovr_dat = 32'h0;
  int          req_cnt = 0, run_len = 0, last_run = 0;

  always @(posedge clk) cyc_n++;

  function automatic logic [31:0] model_rdata(input logic [12:0] adr);
    return ovr_en ? ovr_dat : (32'hC0DE_0000 | {19'd0, adr});
  endfunction

  // Responder + bus monitor
  always @(negedge clk) begin
    bus_t        b;
    logic [12:0] cur;
    if (wbm_cyc_o) begin
      req_cnt++;
      run_len++;
      if (req_cnt == 1) begin
        rise_q.push_back(cyc_n);
        total++;
        if (bus_q.size() == 0) begin
          $display("FAIL bus_unexpected: cycle at adr %08h with no command pending", wbm_adr_o);
        end else begin
          b = bus_q.pop_front();
          if ({wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o} !== {1'b1, b.we, b.adr, b.dat, b.sel})
            $display("FAIL bus_fields: got stb=%0b we=%0b adr=%08h dat=%08h sel=%h expected stb=1 we=%0b adr=%08h dat=%08h sel=%h",
                     wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, b.we, b.adr, b.dat, b.sel);
          else passed++;
        end
      end
    end else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
      req_cnt = 0;
      total++;
      if ({wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o} !== 70'd0)
        $display("FAIL bus_idle_zero: stb=%0b we=%0b sel=%h adr=%08h dat=%08h expected all 0",
                 wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o);
      else passed++;
    end
    cur = wbm_adr_o[12:0];
    wbm_dat_i = wbm_cyc_o ? model_rdata(cur) : 32'hDEAD_BEEF;
    wbm_ack_i = wbm_cyc_o && (ack_after != 0) && (req_cnt == ack_after) && (cur != ERR_ADR);
    wbm_err_i = wbm_cyc_o && (ack_after != 0) && (req_cnt == ack_after) && (cur == ERR_ADR);
  end

  // Response scoreboard: compare at the negedge before the accepting edge
  always @(negedge clk) begin
    rsp_t r;
    if (rsp_valid && rsp_ready) begin
      total++;
      if (rsp_q.size() == 0) begin
        $display("FAIL rsp_stale: got dat=%08h err=%0b we=%0b with no response expected", rsp_dat, rsp_err, rsp_we);
      end else begin
        r = rsp_q.pop_front();
        if ({rsp_dat, rsp_err, rsp_we} !== {r.dat, r.err, r.we})
          $display("FAIL rsp_fields: got dat=%08h err=%0b we=%0b expected dat=%08h err=%0b we=%0b",
                   rsp_dat, rsp_err, rsp_we, r.dat, r.err, r.we);
        else begin
          passed++;
          $display("rsp ok: dat=%08h err=%0b we=%0b", rsp_dat, rsp_err, rsp_we);
        end
      end
    end
  end

  task automatic push_cmd(input logic we, input logic [12:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    bus_t b;
    rsp_t r;
    int   w;
    @(negedge clk);
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      total++;
      $display("FAIL push_wait: cmd_ready=%0b expected 1 within 200 cycles", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    b.we = we; b.adr = {BASE[31:13], adr}; b.dat = dat; b.sel = sel;
    r.err = (adr == ERR_ADR) || (ack_after == 0);
    r.dat = (we || r.err) ? 32'h0 : model_rdata(adr);
    r.we  = we;
    bus_q.push_back(b);
    rsp_q.push_back(r);
    $display("cmd: we=%0b adr=%03h dat=%08h sel=%h", we, adr, dat, sel);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic set_rsp_ready(input logic v);
    @(posedge clk);
    #1 rsp_ready = v;
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while ((rsp_q.size() != 0 || bus_q.size() != 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (rsp_q.size() != 0 || bus_q.size() != 0)
      $display("FAIL drain: %0d responses and %0d bus cycles outstanding, expected 0", rsp_q.size(), bus_q.size());
    else passed++;
  endtask

  task automatic test_reset();
    cmd_valid = 0; cmd_we = 0; cmd_adr = 0; cmd_dat = 0; cmd_sel = 0; rsp_ready = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, rsp_valid, rsp_err, rsp_we, rsp_dat, busy, cmd_ready} !== 108'd1)
      $display("FAIL reset_state: cyc=%0b rsp_valid=%0b rsp_dat=%08h busy=%0b cmd_ready=%0b expected 0/0/0/0/1",
               wbm_cyc_o, rsp_valid, rsp_dat, busy, cmd_ready);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_write();
    ack_after = 2;
    set_rsp_ready(1'b1);
    push_cmd(1'b1, 13'h004, 32'h0000_0001, 4'hF);
    @(negedge clk);
    total++;
    if ({wbm_cyc_o, busy} !== 2'b01) $display("FAIL write_latency_n: cyc=%0b busy=%0b expected cyc=0 busy=1", wbm_cyc_o, busy);
    else passed++;
    @(negedge clk);
    total++;
    if (wbm_cyc_o !== 1'b1) $display("FAIL write_latency_n1: cyc=%0b expected 1", wbm_cyc_o);
    else passed++;
    wait_drain(50);
    total++;
    if (last_run != 2) $display("FAIL write_cyc_len: cyc high %0d cycles expected 2", last_run);
    else passed++;
  endtask

  task automatic test_read();
    ack_after = 1;
    ovr_en = 1'b1;
    ovr_dat = 32'hA5A5_1234;
    push_cmd(1'b0, 13'h010, 32'h0, 4'hF);
    wait_drain(50);
    total++;
    if (last_run != 1) $display("FAIL read_cyc_len: cyc high %0d cycles expected 1", last_run);
    else passed++;
    ovr_en = 1'b0;
  endtask

  task automatic test_fifo_full();
    ack_after = 1;
    set_rsp_ready(1'b0);
    for (int i = 0; i < 5; i++)
      push_cmd(1'(i), 13'h100 + 13'(i * 4), $urandom, 4'(i + 1));
    repeat (3) @(negedge clk);
    total++;
    if ({cmd_ready, busy, rsp_valid} !== 3'b011)
      $display("FAIL fifo_full: cmd_ready=%0b busy=%0b rsp_valid=%0b expected 0/1/1", cmd_ready, busy, rsp_valid);
    else passed++;
    total++;
    if (rsp_q.size() != 5) $display("FAIL fifo_held: %0d responses pending expected 5", rsp_q.size());
    else passed++;
    set_rsp_ready(1'b1);
    wait_drain(200);
  endtask

  task automatic test_err();
    ack_after = 1;
    push_cmd(1'b0, ERR_ADR, 32'h0, 4'hF);
    push_cmd(1'b0, 13'h020, 32'h0, 4'h3);
    wait_drain(100);
  endtask

  task automatic test_back_to_back();
    ack_after = 1;
    rise_q.delete();
    for (int i = 0; i < 4; i++)
      push_cmd(1'(i + 1), 13'h040 + 13'(i * 4), 32'h1000_0000 + 32'(i), 4'hF);
    wait_drain(100);
    total++;
    if (rise_q.size() != 4) $display("FAIL b2b_count: %0d bus cycles expected 4", rise_q.size());
    else passed++;
    for (int i = 1; i < rise_q.size(); i++) begin
      total++;
      if (rise_q[i] - rise_q[i-1] != 3)
        $display("FAIL b2b_spacing: cycle %0d started %0d clocks after previous expected 3", i, rise_q[i] - rise_q[i-1]);
      else passed++;
    end
  endtask

  task automatic test_timeout();
    ack_after = 0;
    push_cmd(1'b0, 13'h030, 32'h0, 4'hF);
`ifdef LDPC_WBM_TIMEOUT_EN
    wait_drain(100);
    total++;
    if (last_run != TO) $display("FAIL timeout_len: cyc high %0d cycles expected %0d", last_run, TO);
    else passed++;
`else
    begin
      int hi = 0;
      @(negedge clk);
      repeat (1000) begin
        @(negedge clk);
        if (wbm_cyc_o) hi++;
      end
      total++;
      if (hi != 1000) $display("FAIL no_timeout: cyc high %0d of 1000 cycles expected 1000", hi);
      else passed++;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      bus_q.delete();
      rsp_q.delete();
    end
`endif
    ack_after = 1;
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    ack_after = 0;
    set_rsp_ready(1'b1);
    for (int i = 0; i < 3; i++) push_cmd(1'b0, 13'h050 + 13'(i * 4), 32'h0, 4'hF);
    @(negedge clk);
    total++;
    if (wbm_cyc_o !== 1'b1) $display("FAIL rst_pre: cyc=%0b expected 1", wbm_cyc_o);
    else passed++;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({wbm_cyc_o, wbm_stb_o} !== 2'b00) $display("FAIL rst_async: cyc=%0b stb=%0b expected 0/0", wbm_cyc_o, wbm_stb_o);
    else passed++;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus_q.delete();
    rsp_q.delete();
    ack_after = 1;
    @(negedge clk);
    total++;
    if ({busy, cmd_ready, rsp_valid} !== 3'b010)
      $display("FAIL rst_release: busy=%0b cmd_ready=%0b rsp_valid=%0b expected 0/1/0", busy, cmd_ready, rsp_valid);
    else passed++;
    repeat (20) begin
      @(negedge clk);
      if (wbm_cyc_o || rsp_valid) stray++;
    end
    total++;
    if (stray != 0) $display("FAIL rst_stale: %0d cycles with cyc or rsp_valid after reset expected 0", stray);
    else passed++;
    push_cmd(1'b0, 13'h060, 32'h0, 4'hF);
    wait_drain(50);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_fifo_full();
    test_err();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit, %0d/%0d passed", passed, total);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/ldpc_wb_initiator.md
# ldpc_wb_initiator

Wishbone classic-cycle initiator that drives the LDPC CSR register window (base 0x3001_0000) from a queued command stream. It lets on-chip logic or a test harness program and poll the LDPC encoder/decoder CSRs without the management SoC. It buffers commands in a small FIFO, executes one single-beat bus cycle at a time, and returns one response per command (read data or write completion, plus error status). An optional watchdog aborts cycles the responder never acknowledges.

## Interface
Parameters:
- ADDR_BASE, 32'h3001_0000, CSR window base; bits [31:13] form the upper address.
- FIFO_DEPTH, 4, command FIFO entries; power of two, at least 2.
- TIMEOUT, 255, REQ-state cycles before abort; 8-bit counter; used only with the watchdog.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_adr  in  13  CSR byte offset.
- cmd_dat  in  32  write data.
- cmd_sel  in  4  byte selects.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_dat  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  bus error or timeout.
- rsp_we  out  1  echoes cmd_we of the completed command.
- wbm_cyc_o, wbm_stb_o  out  1 each  bus cycle and strobe.
- wbm_we_o  out  1  bus write enable.
- wbm_sel_o  out  4  bus byte selects.
- wbm_adr_o  out  32  {ADDR_BASE[31:13], cmd_adr}.
- wbm_dat_o  out  32  bus write data.
- wbm_ack_i, wbm_err_i  in  1 each  responder acknowledge and error.
- wbm_dat_i  in  32  responder read data.
- busy  out  1  state is not IDLE, or the FIFO is not empty.

## Operation
- Command push: cmd_valid & cmd_ready on a rising edge writes {we, adr, dat, sel} into the FIFO.
  - cmd_ready = ~full.
  - A push and a pop in the same cycle leave the count unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE:
    - FIFO non-empty: pop the head into the bus registers, set cyc=stb=1, go to REQ.
  - REQ: cyc, stb, we, sel, adr and dat are held stable.
    - wbm_ack_i: capture rsp_dat = we ? 0 : wbm_dat_i, set rsp_err = 0, drop cyc/stb, go to RSP.
    - Else wbm_err_i: set rsp_dat = 0, rsp_err = 1, drop cyc/stb, go to RSP.
    - If ack and err are both high, ack wins.
  - RSP: rsp_valid = 1, and rsp_dat, rsp_err and rsp_we are held.
    - rsp_valid & rsp_ready: clear rsp_valid, go to IDLE.
    - No new bus cycle starts until the response is consumed.
- wbm_ack_i and wbm_err_i are ignored outside REQ.
- Bus outputs are zero whenever cyc = 0.
- Reset:
  - Outputs: cyc, stb, we, sel, adr, dat_o all 0; rsp_valid, rsp_err, rsp_we 0; rsp_dat 0; busy 0; cmd_ready 1.
  - FIFO is emptied, state goes to IDLE, and the timeout counter is cleared.
  - Reset asserted mid-cycle drops cyc/stb immediately (asynchronous). The in-flight command and any pending response are discarded.

## Timing
- All outputs are registered, except cmd_ready and busy, which are decoded directly from registered state.
- Command accepted at edge N with the FIFO empty and the FSM in IDLE: cyc/stb are high after edge N+1.
- Responder acks in the k-th REQ cycle: cyc/stb drop and rsp_valid rises at the edge ending that cycle.
- rsp_ready held high: the response handshake completes at the next edge, then IDLE lasts one cycle.
  - Back-to-back throughput with zero-wait ack and rsp_ready tied high: one transaction per 3 cycles.
- Response order equals command order; exactly one response per command.

## Configuration
- LDPC_WBM_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to REQ and increments each REQ cycle without ack/err.
  - In the REQ cycle where the counter equals TIMEOUT-1 with no ack/err, the next edge aborts: cyc/stb drop, rsp_err = 1, rsp_dat = 0, go to RSP.
  - The cycle is therefore aborted after exactly TIMEOUT REQ cycles.
  - ack/err arriving in that same cycle takes precedence over the timeout.
- LDPC_WBM_TIMEOUT_EN undefined:
  - No counter is built and REQ waits indefinitely.
  - TIMEOUT is ignored.

## Test plan
- Write 0x0000_0001 to offset 0x004 (sel 4'hF), ack after 2 cycles -> one bus cycle with adr 0x3001_0004, we=1, dat 0x0000_0001; response rsp_we=1, rsp_err=0, rsp_dat=0.
- Read offset 0x010, responder returns 0xA5A5_1234 with ack on the first REQ cycle -> rsp_dat=0xA5A5_1234, rsp_err=0, and cyc is high for exactly 1 cycle.
- Push 5 commands with FIFO_DEPTH=4 while rsp_ready=0 -> cmd_ready falls once the FIFO is full; all commands are eventually issued in order with 5 in-order responses once rsp_ready=1.
- Responder asserts err on a read -> rsp_err=1, rsp_dat=0; the next queued command then proceeds normally.
- With LDPC_WBM_TIMEOUT_EN and TIMEOUT=16, the responder never acks -> cyc drops after 16 REQ cycles with rsp_err=1. Without the macro, cyc stays high for 1000 cycles.
- Assert wb_rst_i during REQ with 2 commands queued -> cyc/stb go low asynchronously, busy=0 and cmd_ready=1 after release, and no stale response appears.
